// File: rtl/lsu_req_queue.sv
// In-order load/store request queue between the execute stage and the data SRAM bus.
// Entries issue to the bus in order, retire in order, and drain silently once flushed.
module lsu_req_queue #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic [ID_W-1:0] in_id,
  output logic            data_sram_req,
  output logic            data_sram_wr,
  output logic [1:0]      data_sram_size,
  output logic [3:0]      data_sram_wstrb,
  output logic [31:0]     data_sram_addr,
  output logic [31:0]     data_sram_wdata,
  input  logic            data_sram_addr_ok,
  input  logic            data_sram_data_ok,
  input  logic [31:0]     data_sram_rdata,
  output logic            resp_valid,
  output logic [ID_W-1:0] resp_id,
  output logic [31:0]     resp_data,
  output logic            resp_ale
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: op_size = 2'd0;
      3'd1, 3'd4, 3'd6: op_size = 2'd1;
      default:          op_size = 2'd2;
    endcase
  endfunction

  function automatic logic op_store(input logic [2:0] op);
    op_store = (op >= 3'd5);
  endfunction

  function automatic logic calc_ale(input logic [2:0] op, input logic [1:0] a);
    case (op_size(op))
      2'd2:    calc_ale = (a != 2'b00);
      2'd1:    calc_ale = a[0];
      default: calc_ale = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] calc_wstrb(input logic [2:0] op, input logic [1:0] a);
    if (!op_store(op)) begin
      calc_wstrb = 4'b0000;
    end else begin
      case (op_size(op))
        2'd0:    calc_wstrb = 4'b0001 << a;
        2'd1:    calc_wstrb = a[1] ? 4'b1100 : 4'b0011;
        default: calc_wstrb = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] op, input logic [31:0] wd);
    case (op_size(op))
      2'd0:    wdata_rep = {4{wd[7:0]}};
      2'd1:    wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (op)
      3'd0:    load_ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_ext = {{16{sh[15]}}, sh[15:0]};
      3'd2:    load_ext = rd;
      3'd3:    load_ext = {24'd0, sh[7:0]};
      3'd4:    load_ext = {16'd0, sh[15:0]};
      default: load_ext = 32'd0;
    endcase
  endfunction

  logic [ID_W-1:0]  id_q    [DEPTH];
  logic [2:0]       op_q    [DEPTH];
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [DEPTH-1:0] valid_q, ale_q, sent_q, canc_q, pass_q;
  logic [PW-1:0]    alloc_q, alloc_d, issue_q, issue_d, retire_q, retire_d;
  logic [PW:0]      count_q, count_d;
  logic             held_q, held_d;

  logic alloc_s, iss_req_s, iss_fire_s, iss_skip_s, ret_held_s, retire_s;

  // Issue/retire decisions and next-state for pointers, occupancy and the hold flag.
  always_comb begin
    in_ready   = !count_q[PW] && !flush;
    alloc_s    = in_valid && in_ready;
    // pass_q marks entries issue has already moved beyond (sent or skipped).
    iss_req_s  = valid_q[issue_q] && !pass_q[issue_q] && !ale_q[issue_q] &&
                 (!canc_q[issue_q] || held_q);
    iss_fire_s = iss_req_s && data_sram_addr_ok;
    iss_skip_s = valid_q[issue_q] && !pass_q[issue_q] &&
                 (ale_q[issue_q] || (canc_q[issue_q] && !held_q));
    ret_held_s = held_q && (issue_q == retire_q);

    if (!valid_q[retire_q]) begin
      retire_s = 1'b0;
    end else if (sent_q[retire_q]) begin
      retire_s = data_sram_data_ok;
    end else if (ale_q[retire_q]) begin
      retire_s = 1'b1;
    end else begin
      retire_s = canc_q[retire_q] && !ret_held_s;
    end

    alloc_d  = alloc_s ? alloc_q + PTR_ONE : alloc_q;
    issue_d  = (iss_fire_s || iss_skip_s) ? issue_q + PTR_ONE : issue_q;
    retire_d = retire_s ? retire_q + PTR_ONE : retire_q;
    held_d   = iss_req_s && !data_sram_addr_ok;
    case ({alloc_s, retire_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Bus request fields and the in-order response, all taken from the head entries.
  always_comb begin
    data_sram_req   = iss_req_s;
    data_sram_wr    = op_store(op_q[issue_q]);
    data_sram_size  = op_size(op_q[issue_q]);
    data_sram_wstrb = calc_wstrb(op_q[issue_q], addr_q[issue_q][1:0]);
    data_sram_addr  = addr_q[issue_q];
    data_sram_wdata = wdata_rep(op_q[issue_q], wdata_q[issue_q]);

    resp_valid = retire_s && !canc_q[retire_q] && !flush;
    resp_ale   = resp_valid && ale_q[retire_q];
    resp_id    = id_q[retire_q];
    if (resp_valid && !ale_q[retire_q]) begin
      resp_data = load_ext(op_q[retire_q], addr_q[retire_q][1:0], data_sram_rdata);
    end else begin
      resp_data = 32'd0;
    end
  end

  // Queue state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q  <= '0;
      issue_q  <= '0;
      retire_q <= '0;
      count_q  <= '0;
      held_q   <= 1'b0;
      valid_q  <= '0;
      ale_q    <= '0;
      sent_q   <= '0;
      canc_q   <= '0;
      pass_q   <= '0;
    end else begin
      alloc_q  <= alloc_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      count_q  <= count_d;
      held_q   <= held_d;
      if (flush) begin
        canc_q <= canc_q | valid_q;
      end
      if (iss_fire_s) begin
        sent_q[issue_q] <= 1'b1;
      end
      if (iss_fire_s || iss_skip_s) begin
        pass_q[issue_q] <= 1'b1;
      end
      if (retire_s) begin
        valid_q[retire_q] <= 1'b0;
      end
      if (alloc_s) begin
        valid_q[alloc_q] <= 1'b1;
        sent_q[alloc_q]  <= 1'b0;
        pass_q[alloc_q]  <= 1'b0;
        canc_q[alloc_q]  <= 1'b0;
        ale_q[alloc_q]   <= calc_ale(in_op, in_addr[1:0]);
        id_q[alloc_q]    <= in_id;
        op_q[alloc_q]    <= in_op;
        addr_q[alloc_q]  <= in_addr;
        wdata_q[alloc_q] <= in_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed bench for lsu_req_queue: literal checks per scenario plus a queue-based
// reference model compared against the DUT on every falling edge.
module tb_lsu_req_queue;

  localparam int DEPTH = 2;
  localparam int ID_W  = 5;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic [2:0]      in_op;
  logic [31:0]     in_addr, in_wdata;
  logic [ID_W-1:0] in_id;
  logic            data_sram_req, data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [3:0]      data_sram_wstrb;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic            data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            resp_valid, resp_ale;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_req_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_id(in_id),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ale(resp_ale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [2:0]      op;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    bit              ale;
    bit              sent;
    bit              canc;
  } ent_t;

  ent_t mq[$];
  int   miss = 0;       // number of queued entries already sent or skipped by issue
  bit   mheld = 1'b0;
  bit   model_ok = 1'b0;

  function automatic int m_bytes(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit m_ale(input logic [2:0] op, input logic [31:0] a);
    return (a % m_bytes(op)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] op, input logic [31:0] a);
    int n;
    logic [3:0] m;
    if (op < 3'd5) return 4'b0000;
    n = m_bytes(op);
    m = 4'((1 << n) - 1);
    return 4'(m << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (m_bytes(op))
      1:       return wd[7:0] * 32'h01010101;
      2:       return wd[15:0] * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int n;
    if (op >= 3'd5) return 32'd0;
    n = m_bytes(op);
    v = rd >> (8 * (a % 4));
    if (n == 4) return rd;
    if (n == 1) v = v & 32'hFF;
    else        v = v & 32'hFFFF;
    if (op == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  bit   e_ready, has, e_req, ret, e_resp;
  ent_t ie, re, tmp;

  always @(negedge clk) begin
    if (!model_ok) begin
      if (reset) begin
        mq.delete();
        miss = 0;
        mheld = 1'b0;
        model_ok = 1'b1;
      end
    end else begin
      e_ready = (mq.size() < DEPTH) && !flush;
      has = miss < mq.size();
      if (has) ie = mq[miss];
      e_req = has && !ie.ale && (!ie.canc || mheld);
      chk("m_in_ready", in_ready, e_ready);
      chk("m_req", data_sram_req, e_req);
      if (e_req) begin
        chk("m_wr", data_sram_wr, (ie.op >= 3'd5));
        chk("m_size", data_sram_size, m_bytes(ie.op) / 2);
        chk("m_wstrb", data_sram_wstrb, m_wstrb(ie.op, ie.addr));
        chk("m_addr", data_sram_addr, ie.addr);
        if (ie.op >= 3'd5) chk("m_wdata", data_sram_wdata, m_wdata(ie.op, ie.wdata));
      end
      ret = 1'b0;
      if (mq.size() > 0) begin
        re = mq[0];
        if (re.sent)                         ret = data_sram_data_ok;
        else if (re.ale)                     ret = 1'b1;
        else if (re.canc && !(mheld && miss == 0)) ret = 1'b1;
      end
      e_resp = ret && !re.canc && !flush;
      chk("m_resp_valid", resp_valid, e_resp);
      if (e_resp) begin
        chk("m_resp_id", resp_id, re.id);
        chk("m_resp_ale", resp_ale, re.ale);
        chk("m_resp_data", resp_data, re.ale ? 32'd0 : m_load(re.op, re.addr, data_sram_rdata));
      end
      if (reset) begin
        mq.delete();
        miss = 0;
        mheld = 1'b0;
      end else begin
        if (e_req && data_sram_addr_ok) begin
          tmp = mq[miss]; tmp.sent = 1'b1; mq[miss] = tmp;
          miss++;
        end else if (has && (ie.ale || (ie.canc && !mheld))) begin
          miss++;
        end
        mheld = e_req && !data_sram_addr_ok;
        if (ret) begin
          void'(mq.pop_front());
          miss--;
        end
        if (flush) begin
          for (int k = 0; k < mq.size(); k++) begin
            tmp = mq[k]; tmp.canc = 1'b1; mq[k] = tmp;
          end
        end
        if (in_valid && e_ready) begin
          tmp.id = in_id; tmp.op = in_op; tmp.addr = in_addr; tmp.wdata = in_wdata;
          tmp.ale = m_ale(in_op, in_addr); tmp.sent = 1'b0; tmp.canc = 1'b0;
          mq.push_back(tmp);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
  endtask

  task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [ID_W-1:0] id);
    in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = wd; in_id = id;
  endtask

  // Single op: accept, immediate addr_ok, data_ok on the next cycle.
  task automatic single(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [ID_W-1:0] id, input logic [31:0] rd,
                        input logic [31:0] exp);
    offer(op, a, 32'd0, id); tick();
    idle(); data_sram_addr_ok = 1'b1; #1;
    chk({nm, "_req"}, data_sram_req, 1'b1);
    chk({nm, "_addr"}, data_sram_addr, a);
    tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = rd; #1;
    chk({nm, "_resp_valid"}, resp_valid, 1'b1);
    chk({nm, "_resp_data"}, resp_data, exp);
    chk({nm, "_resp_id"}, resp_id, id);
    tick(); idle();
  endtask

  initial begin
    reset = 1'b1; idle();
    in_op = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_id = '0; data_sram_rdata = 32'd0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req", data_sram_req, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    tick();

    // ld_w aligned, data_ok two cycles after addr_ok
    offer(3'd2, 32'h100, 32'd0, 5'd3); #1; chk("A_ready", in_ready, 1'b1); tick();
    idle(); data_sram_addr_ok = 1'b1; #1;
    chk("A_req", data_sram_req, 1'b1); chk("A_size", data_sram_size, 2'd2);
    chk("A_wstrb", data_sram_wstrb, 4'b0000); chk("A_wr", data_sram_wr, 1'b0);
    chk("A_addr", data_sram_addr, 32'h100);
    tick();
    idle(); #1; chk("A_req_after_ack", data_sram_req, 1'b0); tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8899AABB; #1;
    chk("A_resp_valid", resp_valid, 1'b1); chk("A_resp_data", resp_data, 32'h8899AABB);
    chk("A_resp_id", resp_id, 5'd3); chk("A_resp_ale", resp_ale, 1'b0);
    tick(); idle(); #1; chk("A_resp_pulse", resp_valid, 1'b0); tick();

    // st_b at byte 3
    offer(3'd5, 32'h103, 32'h12, 5'd4); tick();
    idle(); data_sram_addr_ok = 1'b1; #1;
    chk("B_req", data_sram_req, 1'b1); chk("B_wstrb", data_sram_wstrb, 4'b1000);
    chk("B_wdata", data_sram_wdata, 32'h12121212); chk("B_size", data_sram_size, 2'd0);
    chk("B_wr", data_sram_wr, 1'b1);
    tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF; #1;
    chk("B_resp_valid", resp_valid, 1'b1); chk("B_resp_data", resp_data, 32'd0);
    tick(); idle();

    // misaligned ld_h, then signed/unsigned byte loads
    offer(3'd1, 32'h101, 32'd0, 5'd5); tick();
    idle(); #1;
    chk("C_req", data_sram_req, 1'b0); chk("C_resp_valid", resp_valid, 1'b1);
    chk("C_resp_ale", resp_ale, 1'b1); chk("C_resp_data", resp_data, 32'd0);
    chk("C_resp_id", resp_id, 5'd5);
    tick();
    single("C_ldb", 3'd0, 32'h102, 5'd6, 32'h0080FF00, 32'hFFFFFF80);
    single("C_ldbu", 3'd3, 32'h102, 5'd7, 32'h0080FF00, 32'h00000080);
    single("C_ldhu", 3'd4, 32'h102, 5'd8, 32'h8001FF00, 32'h00008001);

    // DEPTH=2 back-pressure with addr_ok held low
    offer(3'd2, 32'h200, 32'd0, 5'd7); #1; chk("D_rdy0", in_ready, 1'b1); tick();
    offer(3'd2, 32'h204, 32'd0, 5'd8); #1; chk("D_rdy1", in_ready, 1'b1);
    chk("D_req1", data_sram_req, 1'b1); tick();
    offer(3'd2, 32'h208, 32'd0, 5'd9); #1; chk("D_rdy2", in_ready, 1'b0);
    chk("D_addr2", data_sram_addr, 32'h200); tick();
    data_sram_addr_ok = 1'b1; #1; chk("D_addr3", data_sram_addr, 32'h200);
    chk("D_req3", data_sram_req, 1'b1); tick();
    #1; chk("D_addr4", data_sram_addr, 32'h204); tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111; #1;
    chk("D_resp1_id", resp_id, 5'd7); chk("D_rdy6", in_ready, 1'b0); tick();
    data_sram_rdata = 32'h22222222; #1;
    chk("D_resp2_id", resp_id, 5'd8); chk("D_rdy7", in_ready, 1'b1); tick();
    idle(); data_sram_addr_ok = 1'b1; #1; chk("D_addr8", data_sram_addr, 32'h208); tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33333333; #1;
    chk("D_resp3_id", resp_id, 5'd9); chk("D_resp3_data", resp_data, 32'h33333333);
    tick(); idle();

    // flush while a request is held, one entry already sent
    offer(3'd2, 32'h300, 32'd0, 5'd10); tick();
    offer(3'd2, 32'h304, 32'd0, 5'd11); data_sram_addr_ok = 1'b1; tick();
    idle(); #1; chk("E_req_held", data_sram_addr, 32'h304); tick();
    flush = 1'b1; #1; chk("E_req_flush", data_sram_req, 1'b1);
    chk("E_rdy_flush", in_ready, 1'b0); tick();
    idle(); #1; chk("E_req_post", data_sram_req, 1'b1);
    chk("E_addr_post", data_sram_addr, 32'h304); tick();
    data_sram_addr_ok = 1'b1; tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAAAAAA; #1;
    chk("E_resp_silent1", resp_valid, 1'b0); tick();
    offer(3'd2, 32'h308, 32'd0, 5'd12); #1;
    chk("E_resp_silent2", resp_valid, 1'b0); chk("E_rdy_new", in_ready, 1'b1); tick();
    idle(); data_sram_addr_ok = 1'b1; #1; chk("E_new_addr", data_sram_addr, 32'h308); tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h44444444; #1;
    chk("E_new_resp", resp_valid, 1'b1); chk("E_new_id", resp_id, 5'd12); tick(); idle();

    // flush coincident with data_ok
    offer(3'd2, 32'h400, 32'd0, 5'd13); tick();
    idle(); data_sram_addr_ok = 1'b1; tick();
    idle(); data_sram_data_ok = 1'b1; flush = 1'b1; #1;
    chk("F_resp_flush", resp_valid, 1'b0); tick(); idle(); tick();

    // cancelled entry behind a held request is skipped and drains silently
    offer(3'd2, 32'h500, 32'd0, 5'd14); tick();
    offer(3'd2, 32'h504, 32'd0, 5'd15); #1; chk("G_req0", data_sram_addr, 32'h500); tick();
    idle(); flush = 1'b1; tick();
    idle(); data_sram_addr_ok = 1'b1; #1; chk("G_req_held", data_sram_req, 1'b1); tick();
    idle(); #1; chk("G_skip", data_sram_req, 1'b0); tick();
    data_sram_data_ok = 1'b1; #1; chk("G_silent", resp_valid, 1'b0); tick();
    idle(); tick(); tick();

    // reset mid-transfer
    offer(3'd2, 32'h600, 32'd0, 5'd16); tick();
    offer(3'd2, 32'h604, 32'd0, 5'd17); data_sram_addr_ok = 1'b1; tick();
    idle(); reset = 1'b1; #1; chk("H_req_pre", data_sram_req, 1'b1); tick();
    reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55555555; #1;
    chk("H_req", data_sram_req, 1'b0); chk("H_resp", resp_valid, 1'b0);
    chk("H_ready", in_ready, 1'b1); tick(); idle();
    single("H_after", 3'd2, 32'h608, 5'd18, 32'h66666666, 32'h66666666);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
